// File: rtl/hpc2_mul_pipe_if.sv
// rtl/hpc2_mul_pipe_if.sv - operand/result bundle for the masked AND gadget
// master drives operands and randomness, slave (the gadget) drives the product.
interface hpc2_mul_pipe_if #(
    parameter int D = 2,
    parameter int W = 1
);
    logic [D*W-1:0]           port_a;
    logic [D*W-1:0]           port_b;
    logic [(D*(D-1)/2)*W-1:0] port_r;
    logic                     in_valid;
    logic [D*W-1:0]           port_c;
    logic                     out_valid;

    modport master (
        output port_a, port_b, port_r, in_valid,
        input  port_c, out_valid
    );

    modport slave (
        input  port_a, port_b, port_r, in_valid,
        output port_c, out_valid
    );
endinterface

// File: rtl/hpc2_mul_pipe.sv
// rtl/hpc2_mul_pipe.sv - pipelined HPC2 masked AND gadget, D shares x W lanes
// HPC2_MUL_OUTREG_EN adds a registered output stage (latency 3 instead of 2).
module hpc2_mul_pipe #(
    parameter int D = 2,
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           reset,
    hpc2_mul_pipe_if.slave bus
);
    function automatic int pair_idx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo*D - (lo*(lo+1))/2 + (hi-lo-1);
    endfunction

    logic [W-1:0] w_a [D];
    logic [W-1:0] w_b [D];
    logic [W-1:0] w_r [D][D];

    always_comb begin
        for (int i = 0; i < D; i++) begin
            w_a[i] = bus.port_a[i*W +: W];
            w_b[i] = bus.port_b[i*W +: W];
            for (int j = 0; j < D; j++) begin
                w_r[i][j] = '0;
                if (i != j) begin
                    w_r[i][j] = bus.port_r[pair_idx(i, j)*W +: W];
                end
            end
        end
    end

    // Stage 1: b_j leaves this stage only after masking with r_ij.
    logic [W-1:0] r_s  [D][D];
    logic [W-1:0] r_q  [D][D];
    logic [W-1:0] r_ad [D];
    logic [W-1:0] r_p  [D];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                r_ad[i] <= '0;
                r_p[i]  <= '0;
                for (int j = 0; j < D; j++) begin
                    r_s[i][j] <= '0;
                    r_q[i][j] <= '0;
                end
            end
        end else if (bus.in_valid) begin
            for (int i = 0; i < D; i++) begin
                r_ad[i] <= w_a[i];
                r_p[i]  <= w_a[i] & w_b[i];
                for (int j = 0; j < D; j++) begin
                    if (i != j) begin
                        r_s[i][j] <= w_b[j] ^ w_r[i][j];
                        r_q[i][j] <= w_r[i][j];
                    end else begin
                        r_s[i][j] <= '0;
                        r_q[i][j] <= '0;
                    end
                end
            end
        end
    end

    // Stage 2: a_i only ever meets registered, already-masked values.
    logic [W-1:0] r_m  [D][D];
    logic [W-1:0] r_n  [D][D];
    logic [W-1:0] r_pp [D];
    logic         r_v1;
    logic         r_v2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                r_pp[i] <= '0;
                for (int j = 0; j < D; j++) begin
                    r_m[i][j] <= '0;
                    r_n[i][j] <= '0;
                end
            end
        end else if (r_v1) begin
            for (int i = 0; i < D; i++) begin
                r_pp[i] <= r_p[i];
                for (int j = 0; j < D; j++) begin
                    if (i != j) begin
                        r_m[i][j] <= r_ad[i] & r_s[i][j];
                        r_n[i][j] <= ~r_ad[i] & r_q[i][j];
                    end else begin
                        r_m[i][j] <= '0;
                        r_n[i][j] <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= bus.in_valid;
            r_v2 <= r_v1;
        end
    end

    // Output compression: XOR-only over stage-2 flops.
    logic [D*W-1:0] w_c;

    always_comb begin
        w_c = '0;
        for (int i = 0; i < D; i++) begin
            w_c[i*W +: W] = r_pp[i];
            for (int j = 0; j < D; j++) begin
                if (i != j) begin
                    w_c[i*W +: W] = w_c[i*W +: W] ^ r_m[i][j] ^ r_n[i][j];
                end
            end
        end
    end

`ifdef HPC2_MUL_OUTREG_EN
    logic [D*W-1:0] r_c;
    logic           r_v3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c  <= '0;
            r_v3 <= 1'b0;
        end else begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_c <= w_c;
            end
        end
    end

    assign bus.port_c    = r_c;
    assign bus.out_valid = r_v3;
`else
    assign bus.port_c    = w_c;
    assign bus.out_valid = r_v2;
`endif
endmodule

// File: tb/tb_hpc2_mul_pipe.sv
// tb/tb_hpc2_mul_pipe.sv - directed and scoreboard bench for hpc2_mul_pipe
// Two instances: D=2/W=8 for latency, hold and reset; D=3/W=4 for vectors and streams.
module tb_hpc2_mul_pipe;
`ifdef HPC2_MUL_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int NV = 8;
    localparam int NR = 300;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    hpc2_mul_pipe_if #(.D(2), .W(8)) if_a ();
    hpc2_mul_pipe_if #(.D(3), .W(4)) if_b ();

    hpc2_mul_pipe #(.D(2), .W(8)) u_dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    hpc2_mul_pipe #(.D(3), .W(4)) u_dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  x;
        logic [3:0]  y;
        logic [7:0]  ma;
        logic [7:0]  mb;
        logic [11:0] r;
        logic [3:0]  exp;
    } vec_t;

    vec_t tbl [NV];
    logic v_hist [NR];
    logic [3:0] e_hist [NR];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] un_a(input logic [15:0] c);
        return c[7:0] ^ c[15:8];
    endfunction

    function automatic logic [3:0] un_b(input logic [11:0] c);
        return c[3:0] ^ c[7:4] ^ c[11:8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] r, input logic [7:0] exp);
        if_a.port_a   = a;
        if_a.port_b   = b;
        if_a.port_r   = r;
        if_a.in_valid = 1'b1;
        tick();
        if_a.in_valid = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            chk({nm, "_early_valid"}, 32'(if_a.out_valid), 32'd0);
            tick();
        end
        chk({nm, "_valid"}, 32'(if_a.out_valid), 32'd1);
        chk({nm, "_data"}, 32'(un_a(if_a.port_c)), 32'(exp));
    endtask

    initial begin
        logic [11:0] sa;
        logic [11:0] sb;
        logic [3:0]  xa;
        logic [3:0]  xb;
        logic [3:0]  last;
        int          idx;

        tests = 0;
        fails = 0;
        reset = 1'b1;
        if_a.port_a = '0; if_a.port_b = '0; if_a.port_r = '0; if_a.in_valid = 1'b0;
        if_b.port_a = '0; if_b.port_b = '0; if_b.port_r = '0; if_b.in_valid = 1'b0;

        //            x     y     ma      mb      r         exp
        tbl[0] = '{4'hF, 4'hF, 8'h3A, 8'hC5, 12'h9E1, 4'hF};
        tbl[1] = '{4'hA, 4'h5, 8'h71, 8'h0F, 12'h000, 4'h0};
        tbl[2] = '{4'hC, 4'hA, 8'hE2, 8'h58, 12'h7B3, 4'h8};
        tbl[3] = '{4'h0, 4'hF, 8'h96, 8'h21, 12'hF0F, 4'h0};
        tbl[4] = '{4'h7, 4'hE, 8'h00, 8'hFF, 12'h000, 4'h6};
        tbl[5] = '{4'h9, 4'hB, 8'h4D, 8'hB2, 12'h5A5, 4'h9};
        tbl[6] = '{4'h6, 4'h3, 8'hAC, 8'h13, 12'h000, 4'h2};
        tbl[7] = '{4'hF, 4'h1, 8'h5F, 8'hE4, 12'hC3C, 4'h1};

        tick();
        tick();
        chk("rst_a_valid", 32'(if_a.out_valid), 32'd0);
        chk("rst_a_c", 32'(if_a.port_c), 32'd0);
        chk("rst_b_valid", 32'(if_b.out_valid), 32'd0);
        chk("rst_b_c", 32'(if_b.port_c), 32'd0);
        reset = 1'b0;
        tick();

        // Single-bit scenario on lane 0 of the D=2 instance.
        run_a("and_1_0", {8'h00, 8'h01}, {8'h01, 8'h01}, 8'h01, 8'h00);
        run_a("and_1_1", {8'h00, 8'h01}, {8'h00, 8'h01}, 8'h01, 8'h01);

        // Full-width op then five idle cycles with noisy inputs: result must hold.
        run_a("a5", {8'h99, 8'h3C}, {8'hF0, 8'h0F}, 8'h6B, 8'hA5);
        for (int k = 0; k < 5; k++) begin
            if_a.port_a = 16'($urandom);
            if_a.port_b = 16'($urandom);
            if_a.port_r = 8'($urandom);
            tick();
            chk("hold_valid", 32'(if_a.out_valid), 32'd0);
            chk("hold_data", 32'(un_a(if_a.port_c)), 32'hA5);
        end

        // Reset one cycle after an accepted op: immediate clear, no stale pulse.
        if_a.port_a = {8'h12, 8'h34};
        if_a.port_b = {8'h56, 8'h78};
        if_a.in_valid = 1'b1;
        tick();
        if_a.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_c", 32'(if_a.port_c), 32'd0);
        chk("arst_valid", 32'(if_a.out_valid), 32'd0);
        if_a.in_valid = 1'b1;
        tick();
        reset = 1'b0;
        if_a.in_valid = 1'b0;
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            chk("post_rst_valid", 32'(if_a.out_valid), 32'd0);
            chk("post_rst_c", 32'(if_a.port_c), 32'd0);
        end

        // Table vectors, back-to-back on the D=3 instance.
        for (int t = 0; t < NV + LAT; t++) begin
            if (t < NV) begin
                sa = {tbl[t].x ^ tbl[t].ma[3:0] ^ tbl[t].ma[7:4], tbl[t].ma[7:4], tbl[t].ma[3:0]};
                sb = {tbl[t].y ^ tbl[t].mb[3:0] ^ tbl[t].mb[7:4], tbl[t].mb[7:4], tbl[t].mb[3:0]};
                if_b.port_a   = sa;
                if_b.port_b   = sb;
                if_b.port_r   = tbl[t].r;
                if_b.in_valid = 1'b1;
            end else begin
                if_b.in_valid = 1'b0;
            end
            tick();
            idx = t - LAT + 1;
            if (idx >= 0 && idx < NV) begin
                chk("vec_valid", 32'(if_b.out_valid), 32'd1);
                chk($sformatf("vec%0d_data", idx), 32'(un_b(if_b.port_c)), 32'(tbl[idx].exp));
            end else begin
                chk("vec_gap_valid", 32'(if_b.out_valid), 32'd0);
            end
        end

        // Random stream with bubbles: scoreboard on unmasked values and valid timing.
        last = tbl[NV-1].exp;
        for (int t = 0; t < NR; t++) begin
            sa = 12'($urandom);
            sb = 12'($urandom);
            xa = sa[3:0] ^ sa[7:4] ^ sa[11:8];
            xb = sb[3:0] ^ sb[7:4] ^ sb[11:8];
            v_hist[t] = ($urandom_range(0, 3) != 0);
            e_hist[t] = xa & xb;
            if_b.port_a   = sa;
            if_b.port_b   = sb;
            if_b.port_r   = 12'($urandom);
            if_b.in_valid = v_hist[t];
            tick();
            idx = t - LAT + 1;
            if (idx >= 0 && v_hist[idx]) begin
                chk("rnd_valid", 32'(if_b.out_valid), 32'd1);
                chk("rnd_data", 32'(un_b(if_b.port_c)), 32'(e_hist[idx]));
                last = e_hist[idx];
            end else begin
                chk("rnd_bubble_valid", 32'(if_b.out_valid), 32'd0);
                chk("rnd_bubble_hold", 32'(un_b(if_b.port_c)), 32'(last));
            end
        end
        if_b.in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
